// File: rtl/risc16_register_file.sv
// RISC16 register file: two combinational read ports, one synchronous write port, register 0 hardwired to zero.
// Optional write-through bypass on the read ports is enabled by defining RISC16_REGFILE_BYPASS_EN.
module risc16_register_file #(
    parameter int WORD_LENGTH  = 16,
    parameter int REG_ADDR_LEN = 3,
    parameter int REG_NUM      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REG_ADDR_LEN-1:0] addr1,
    output logic [WORD_LENGTH-1:0]  src1,
    input  logic [REG_ADDR_LEN-1:0] addr2,
    output logic [WORD_LENGTH-1:0]  src2,
    input  logic [REG_ADDR_LEN-1:0] addrT,
    input  logic [WORD_LENGTH-1:0]  trgt,
    input  logic                    wen
);

    // Register 0 has no storage; it and any address >= REG_NUM fall through the read muxes as zero.
    logic [WORD_LENGTH-1:0] regs_q [1:REG_NUM-1];
    logic [WORD_LENGTH-1:0] regs_d [1:REG_NUM-1];
    logic [REG_NUM-1:1]     wr_sel_s;
    logic [WORD_LENGTH-1:0] rd1_s;
    logic [WORD_LENGTH-1:0] rd2_s;

    // Write target decode: one-hot over the stored registers, empty for r0 and out-of-range targets.
    always_comb begin
        wr_sel_s = '0;
        for (int k = 1; k < REG_NUM; k++) begin
            wr_sel_s[k] = (addrT == REG_ADDR_LEN'(k)) ? wen : 1'b0;
        end
    end

    // Next-state values for each stored register.
    always_comb begin
        for (int k = 1; k < REG_NUM; k++) begin
            regs_d[k] = wr_sel_s[k] ? trgt : regs_q[k];
        end
    end

    // Register update; reset wins over a simultaneous write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k < REG_NUM; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            for (int k = 1; k < REG_NUM; k++) begin
                regs_q[k] <= regs_d[k];
            end
        end
    end

    // Read port 1 mux over the stored registers.
    always_comb begin
        rd1_s = '0;
        for (int k = 1; k < REG_NUM; k++) begin
            rd1_s = (addr1 == REG_ADDR_LEN'(k)) ? regs_q[k] : rd1_s;
        end
    end

    // Read port 2 mux over the stored registers.
    always_comb begin
        rd2_s = '0;
        for (int k = 1; k < REG_NUM; k++) begin
            rd2_s = (addr2 == REG_ADDR_LEN'(k)) ? regs_q[k] : rd2_s;
        end
    end

`ifdef RISC16_REGFILE_BYPASS_EN
    logic wr_live_s;

    // A write that will land this edge is forwarded to any read port addressing the same register.
    always_comb begin
        wr_live_s = (|wr_sel_s) & ~rst;
        src1      = (wr_live_s && (addr1 == addrT)) ? trgt : rd1_s;
        src2      = (wr_live_s && (addr2 == addrT)) ? trgt : rd2_s;
    end
`else
    assign src1 = rd1_s;
    assign src2 = rd2_s;
`endif

endmodule

// File: tb/tb_risc16_register_file.sv
// Scoreboard bench for risc16_register_file: driver pushes expected reads from a behavioural model, a monitor checks them.
module tb_risc16_register_file;

    logic        clk;
    logic        rst;
    logic [2:0]  addr1;
    logic [2:0]  addr2;
    logic [2:0]  addrT;
    logic [15:0] trgt;
    logic        wen;
    logic [15:0] src1;
    logic [15:0] src2;

    risc16_register_file #(
        .WORD_LENGTH (16),
        .REG_ADDR_LEN(3),
        .REG_NUM     (8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .addr1(addr1),
        .src1 (src1),
        .addr2(addr2),
        .src2 (src2),
        .addrT(addrT),
        .trgt (trgt),
        .wen  (wen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [2:0]  a1;
        logic [2:0]  a2;
        logic [15:0] e1;
        logic [15:0] e2;
    } exp_t;

    exp_t        exp_q[$];
    event        push_ev;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc_cnt = 0;
    logic [15:0] model [8];

    // Reference: what a read should return given the model and this cycle's write request.
    function automatic logic [15:0] expect_read(input logic [2:0] a, input logic r, input logic w,
                                                input logic [2:0] t, input logic [15:0] d);
        logic [15:0] v;
        v = (a == 3'd0) ? 16'h0000 : model[a];
`ifdef RISC16_REGFILE_BYPASS_EN
        if (w && !r && t != 3'd0 && a == t) v = d;
`endif
        return v;
    endfunction

    // One clock cycle: drive at negedge, publish expectations, then apply the write/reset to the model.
    task automatic cycle(input logic r, input logic w, input logic [2:0] t, input logic [15:0] d,
                         input logic [2:0] a1, input logic [2:0] a2);
        exp_t e;
        @(negedge clk);
        rst = r; wen = w; addrT = t; trgt = d; addr1 = a1; addr2 = a2;
        #1;
        e.cyc = cyc_cnt; e.a1 = a1; e.a2 = a2;
        e.e1 = expect_read(a1, r, w, t, d);
        e.e2 = expect_read(a2, r, w, t, d);
        exp_q.push_back(e);
        -> push_ev;
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < 8; k++) model[k] = 16'h0000;
        end else if (w && t != 3'd0) begin
            model[t] = d;
        end
        cyc_cnt++;
    endtask

    // Monitor: compare DUT read ports against each published expectation.
    initial begin
        exp_t e;
        forever begin
            @(push_ev);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (src1 !== e.e1) begin
                    n_fail++;
                    $display("FAIL src1 cyc=%0d addr1=%0d got=%h exp=%h", e.cyc, e.a1, src1, e.e1);
                end
                n_tests++;
                if (src2 !== e.e2) begin
                    n_fail++;
                    $display("FAIL src2 cyc=%0d addr2=%0d got=%h exp=%h", e.cyc, e.a2, src2, e.e2);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; wen = 1'b0; addrT = 3'd0; trgt = 16'h0000; addr1 = 3'd0; addr2 = 3'd0;
        for (int k = 0; k < 8; k++) model[k] = 16'h0000;

        // r0 reads zero even before reset; reset pulse, then sweep all addresses
        cycle(1'b1, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 3'd0, 16'h0000, 3'(i), 3'(7 - i));

        // write r1 then read on both ports
        cycle(1'b0, 1'b1, 3'd1, 16'h1234, 3'd0, 3'd0);
        cycle(1'b0, 1'b0, 3'd0, 16'h0000, 3'd1, 3'd1);

        // reset clears r1
        cycle(1'b1, 1'b0, 3'd0, 16'h0000, 3'd1, 3'd1);
        cycle(1'b0, 1'b0, 3'd0, 16'h0000, 3'd1, 3'd2);

        // write to r0 ignored, checked before and after the edge
        cycle(1'b0, 1'b1, 3'd0, 16'h2356, 3'd0, 3'd0);
        cycle(1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0);

        // reset beats a same-edge write
        cycle(1'b0, 1'b1, 3'd3, 16'h7777, 3'd3, 3'd0);
        cycle(1'b1, 1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd3);
        cycle(1'b0, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd3);

        // same-cycle read of the register being written (old value, or trgt with bypass)
        cycle(1'b0, 1'b1, 3'd2, 16'h1111, 3'd0, 3'd0);
        cycle(1'b0, 1'b1, 3'd2, 16'hA5A5, 3'd2, 3'd1);
        cycle(1'b0, 1'b0, 3'd0, 16'h0000, 3'd2, 3'd2);

        // wen=0 must not change anything
        cycle(1'b0, 1'b0, 3'd2, 16'hFFFF, 3'd2, 3'd2);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)),
                  16'($urandom),
                  3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)));
        end

        // bounded drain of anything still queued
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/risc16_register_file.md
RISC16_REGISTER_FILE -- requirements
Module: risc16_register_file

Interface
REQ-001 Parameter WORD_LENGTH, default 16, SHALL set the register and data-port width in bits.
REQ-002 Parameter REG_ADDR_LEN, default 3, SHALL set the address-port width in bits.
REQ-003 Parameter REG_NUM, default 8, SHALL set the number of registers; legal range is 2..2^REG_ADDR_LEN.
REQ-004 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-005 rst  input  1  SHALL be the reset; it is synchronous and active-high.
REQ-006 addr1  input  REG_ADDR_LEN  SHALL select the register driven on src1.
REQ-007 src1  output  WORD_LENGTH  SHALL carry read port 1 data.
REQ-008 addr2  input  REG_ADDR_LEN  SHALL select the register driven on src2.
REQ-009 src2  output  WORD_LENGTH  SHALL carry read port 2 data.
REQ-010 addrT  input  REG_ADDR_LEN  SHALL select the write target register.
REQ-011 trgt  input  WORD_LENGTH  SHALL carry the write data.
REQ-012 wen  input  1  SHALL be the write enable; it is active-high.

Function
REQ-013 Both read ports SHALL be combinational: src1/src2 reflect the addressed register in the same cycle, with zero clock latency.
REQ-014 The two read ports SHALL be independent; same or different addresses give correct simultaneous data.
REQ-015 On a rising clk edge with wen=1, rst=0 and addrT!=0, the block SHALL write trgt into register addrT; the new value SHALL be visible on the read ports immediately after that edge.
REQ-016 Register 0 SHALL read as all-zeros at all times; writes to addrT=0 SHALL be ignored.
REQ-017 With wen=0, no register SHALL change.
REQ-018 An address >= REG_NUM SHALL read as zero; a write to such an address SHALL be ignored.
REQ-019 Without the bypass feature, a read of the register being written in the same cycle SHALL return the old value until the clock edge.
REQ-020 Only one write per cycle SHALL occur; the block has no write-conflict logic.

Reset
REQ-021 On a rising clk edge with rst=1, the block SHALL clear all registers to 0; src1 and src2 SHALL read 0 after that edge.
REQ-022 When rst=1 and wen=1 occur on the same edge, rst SHALL take precedence and the write SHALL be discarded.
REQ-023 Before the first reset, register contents are undefined except register 0, which SHALL read 0.

Configuration
REQ-024 Macro RISC16_REGFILE_BYPASS_EN SHALL control the write-through bypass feature.
- Defined: when wen=1, rst=0, addrT!=0 and addrN==addrT (N = 1 or 2), srcN SHALL combinationally return trgt in the same cycle.
- Undefined: REQ-019 applies, with no bypass path.
REQ-025 All other behaviour SHALL be identical with or without RISC16_REGFILE_BYPASS_EN.

Verification
REQ-026 The bench SHALL cover the following directed scenarios:
- Pulse rst for one edge, then sweep addr1/addr2 over 0..7 -> all reads 0.
- addrT=1, trgt=0x1234, wen=1 for one edge, then addr1=1 -> src1=0x1234 after the edge; src2 with addr2=1 also 0x1234.
- With r1=0x1234, assert rst for one edge -> src1 (addr1=1) = 0x0000.
- addrT=0, trgt=0x2356, wen=1, addr1=0 -> src1 stays 0x0000 before and after the edge.
- rst=1 and wen=1 on the same edge with addrT=3, trgt=0xBEEF -> r3 reads 0x0000.
- addrT=2, trgt=0xA5A5, wen=1, addr1=2 before the edge -> src1=0xA5A5 if RISC16_REGFILE_BYPASS_EN is defined, else the old value until the edge.
